// File: rtl/conv_enc_pkg.sv
// ------------------------------------------------------------------
// conv_enc_pkg : shared types and constants for the (7,5) encoder path
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package conv_enc_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      DATA = 3'd2,
      TAIL = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam int c_conv_k = 3;

   // Generator taps, newest bit in the MSB: z[1] uses g0, z[0] uses g1.
   localparam logic [2:0] c_g0 = 3'b111;
   localparam logic [2:0] c_g1 = 3'b101;

endpackage

`default_nettype wire

// File: rtl/conv_frame_cnt.sv
// ------------------------------------------------------------------
// conv_frame_cnt : loadable up-counter with terminal-compare flag
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module conv_frame_cnt
   import conv_enc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic [WIDTH-1:0] term_val,
   output logic             at_term
);

   logic [WIDTH-1:0] r_cnt;

   // Load wins over increment so a terminal transfer can restart the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (inc) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign at_term = (r_cnt == term_val);

endmodule

`default_nettype wire

// File: rtl/conv_enc_frame_ctrl.sv
// ------------------------------------------------------------------
// conv_enc_frame_ctrl : frame sequencer for the rate-1/2 encoder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module conv_enc_frame_ctrl
   import conv_enc_pkg::*;
#(
   parameter int FRAME_LEN = 8,
   parameter int K         = c_conv_k,
   parameter int TAIL_EN   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       in_bit,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       enc_x,
   output logic       enc_ce,
   output logic       enc_clr,
   input  logic [1:0] enc_z,
   output logic [1:0] out_z,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy,
   output logic       done
);

   // Sized for whichever of the data or tail phases counts further.
   localparam int CNT_W = $clog2(((FRAME_LEN > K) ? FRAME_LEN : K) + 1);

   localparam bit               c_has_tail  = (TAIL_EN != 0) && (K > 1);
   localparam logic [CNT_W-1:0] c_data_term = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] c_tail_term = CNT_W'((K > 1) ? K - 2 : 0);

   state_t           r_state;
   state_t           w_state_nxt;
   state_t           w_last_state;
   logic             w_cnt_load;
   logic             w_cnt_inc;
   logic             w_at_term;
   logic [CNT_W-1:0] w_term;

   generate
      if (c_has_tail) begin : g_tail
         assign w_last_state = TAIL;
      end else begin : g_no_tail
         assign w_last_state = DATA;
      end
   endgenerate

   assign w_term = (r_state == TAIL) ? c_tail_term : c_data_term;

   conv_frame_cnt #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (w_cnt_load),
      .load_val ('0),
      .inc      (w_cnt_inc),
      .term_val (w_term),
      .at_term  (w_at_term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      enc_x       = 1'b0;
      enc_clr     = 1'b0;
      out_valid   = 1'b0;
      done        = 1'b0;
      w_cnt_load  = 1'b0;
      w_cnt_inc   = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = CLR;
            end
         end
         CLR: begin
            enc_clr     = 1'b1;
            w_cnt_load  = 1'b1;
            w_state_nxt = DATA;
         end
         DATA: begin
            // A source bit is only taken together with the symbol it produces.
            enc_x     = in_bit;
            out_valid = in_valid;
            in_ready  = out_ready;
            if (in_valid && out_ready) begin
               w_cnt_inc = 1'b1;
               if (w_at_term) begin
                  w_cnt_load  = 1'b1;
                  w_state_nxt = c_has_tail ? TAIL : DONE;
               end
            end
         end
         TAIL: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_cnt_inc = 1'b1;
               if (w_at_term) begin
                  w_cnt_load  = 1'b1;
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      if (abort) begin
         w_state_nxt = IDLE;
         in_ready    = 1'b0;
         out_valid   = 1'b0;
         done        = 1'b0;
         w_cnt_load  = 1'b1;
         w_cnt_inc   = 1'b0;
      end

      enc_ce = out_valid && out_ready;
   end

   assign out_z    = enc_z;
   assign out_last = out_valid && w_at_term && (r_state == w_last_state);
   assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conv_enc_frame_ctrl.sv
// ------------------------------------------------------------------
// tb_conv_enc_frame_ctrl : directed bench with a (7,5) encoder model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_conv_enc_frame_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       a_start, a_abort, a_in_bit, a_in_valid, a_in_ready;
   logic       a_enc_x, a_enc_ce, a_enc_clr, a_out_valid, a_out_ready;
   logic       a_out_last, a_busy, a_done;
   logic [1:0] a_enc_z, a_out_z;

   logic       b_start, b_abort, b_in_bit, b_in_valid, b_in_ready;
   logic       b_enc_x, b_enc_ce, b_enc_clr, b_out_valid, b_out_ready;
   logic       b_out_last, b_busy, b_done;
   logic [1:0] b_enc_z, b_out_z;

   conv_enc_frame_ctrl dut_a (
      .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
      .in_bit(a_in_bit), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .enc_x(a_enc_x), .enc_ce(a_enc_ce), .enc_clr(a_enc_clr), .enc_z(a_enc_z),
      .out_z(a_out_z), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_last(a_out_last), .busy(a_busy), .done(a_done)
   );

   conv_enc_frame_ctrl #(.FRAME_LEN(4), .K(3), .TAIL_EN(0)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
      .in_bit(b_in_bit), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .enc_x(b_enc_x), .enc_ce(b_enc_ce), .enc_clr(b_enc_clr), .enc_z(b_enc_z),
      .out_z(b_out_z), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_last(b_out_last), .busy(b_busy), .done(b_done)
   );

   // Encoder models: s[0] is the previous bit, s[1] the one before.
   logic [1:0] sa, sb;
   always @(posedge clk or posedge rst) begin
      if (rst)            sa <= 2'b00;
      else if (a_enc_clr) sa <= 2'b00;
      else if (a_enc_ce)  sa <= {sa[0], a_enc_x};
   end
   always @(posedge clk or posedge rst) begin
      if (rst)            sb <= 2'b00;
      else if (b_enc_clr) sb <= 2'b00;
      else if (b_enc_ce)  sb <= {sb[0], b_enc_x};
   end
   assign a_enc_z = {a_enc_x ^ sa[0] ^ sa[1], a_enc_x ^ sa[1]};
   assign b_enc_z = {b_enc_x ^ sb[0] ^ sb[1], b_enc_x ^ sb[1]};

   logic [2:0] q_a[$];
   logic [2:0] q_b[$];
   int cyc = 0, ce_a = 0, stall_ce = 0, rdy_viol = 0, done_a = 0, done_b = 0;
   int last_cyc_a = 0, done_cyc_a = 0;
   logic stalling;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (a_out_valid && a_out_ready) begin
            q_a.push_back({a_out_last, a_out_z});
            if (a_out_last) last_cyc_a <= cyc;
         end
         if (a_enc_ce) ce_a <= ce_a + 1;
         if (a_enc_ce && stalling) stall_ce <= stall_ce + 1;
         if (a_in_ready && !a_out_ready) rdy_viol <= rdy_viol + 1;
         if (a_done) begin
            done_a     <= done_a + 1;
            done_cyc_a <= cyc;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (b_out_valid && b_out_ready) q_b.push_back({b_out_last, b_out_z});
         if (b_done) done_b <= done_b + 1;
      end
   end

   localparam logic [1:0] EXP_A [10] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b01,
                                         2'b10, 2'b01, 2'b00, 2'b10, 2'b11};
   localparam logic [1:0] EXP_B [4]  = '{2'b11, 2'b10, 2'b00, 2'b01};

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_seq_a(input string tag, input int base);
      logic [2:0] got;
      check({tag, "_len"}, 32'(q_a.size() - base), 32'd10);
      for (int i = 0; i < 10; i++) begin
         got = (base + i < q_a.size()) ? q_a[base + i] : 3'bxxx;
         check($sformatf("%s_z%0d", tag, i), 32'(got[1:0]), 32'(EXP_A[i]));
         check($sformatf("%s_last%0d", tag, i), 32'(got[2]), 32'(i == 9));
      end
   endtask

   // mode 0 nominal, 1 out_ready toggling, 2 source stall, 3 async reset in TAIL
   task automatic drive_a(input logic [7:0] bits, input int mode, input int abort_after,
                          output bit fin);
      int idx, xfers, stall_cnt;
      idx = 0; xfers = 0; stall_cnt = 0; fin = 1'b0;
      a_start = 1'b1; a_in_valid = 1'b1; a_in_bit = bits[0]; a_out_ready = 1'b1;
      @(negedge clk); #1;
      a_start = 1'b0;
      if (mode == 0) begin
         check("lat_clr", 32'(a_enc_clr), 32'd1);
         check("lat_clr_no_valid", 32'(a_out_valid), 32'd0);
      end
      for (int c = 0; c < 200 && !fin; c++) begin
         stalling = (mode == 2) && (xfers == 3) && (stall_cnt < 3);
         if (stalling) stall_cnt++;
         a_in_valid  = (idx < 8) && !stalling;
         a_in_bit    = (idx < 8) ? bits[idx[2:0]] : 1'b0;
         a_out_ready = (mode == 1) ? c[0] : 1'b1;
         a_abort     = (abort_after > 0) && (xfers == abort_after);
         #1;
         if (mode == 0 && c == 1) check("lat_first_valid", 32'(a_out_valid), 32'd1);
         if (a_abort) begin
            check("abort_valid", 32'(a_out_valid), 32'd0);
            check("abort_ce", 32'(a_enc_ce), 32'd0);
            @(negedge clk); a_abort = 1'b0; #1;
            check("abort_idle", 32'(a_busy), 32'd0);
            check("abort_no_done", 32'(a_done), 32'd0);
            fin = 1'b1;
         end else if (mode == 3 && xfers == 8) begin
            rst = 1'b1; #1;
            check("rst_busy", 32'(a_busy), 32'd0);
            check("rst_valid", 32'(a_out_valid), 32'd0);
            fin = 1'b1;
         end else if (a_done) begin
            fin = 1'b1;
         end else begin
            if (a_in_valid && a_in_ready) idx++;
            if (a_out_valid && a_out_ready) xfers++;
            @(negedge clk); #1;
         end
      end
      stalling = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
   endtask

   localparam logic [7:0] FRAME_A = 8'b1011_1011;   // bits 1,1,0,1,1,1,0,1 from bit 0 up
   localparam logic [3:0] FRAME_B = 4'b1101;        // bits 1,0,1,1 from bit 0 up

   int  base, ce0, d0, v0, s0, idx_b;
   bit  fin;

   initial begin
      rst = 1'b1; stalling = 1'b0;
      a_start = 0; a_abort = 0; a_in_bit = 0; a_in_valid = 0; a_out_ready = 1;
      b_start = 0; b_abort = 0; b_in_bit = 0; b_in_valid = 0; b_out_ready = 1;
      #12;
      check("rst_busy_a", 32'(a_busy), 32'd0);
      check("rst_in_ready", 32'(a_in_ready), 32'd0);
      check("rst_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_enc_ce", 32'(a_enc_ce), 32'd0);
      check("rst_enc_clr", 32'(a_enc_clr), 32'd0);
      check("rst_out_last", 32'(a_out_last), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      check("rst_busy_b", 32'(b_busy), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); #1;

      // Nominal frame
      base = q_a.size(); ce0 = ce_a; d0 = done_a;
      drive_a(FRAME_A, 0, 0, fin);
      check("t1_end", 32'(fin), 32'd1);
      @(negedge clk); #1;
      check_seq_a("t1", base);
      check("t1_done_cnt", 32'(done_a - d0), 32'd1);
      check("t1_done_delay", 32'(done_cyc_a - last_cyc_a), 32'd1);
      check("t1_ce_cnt", 32'(ce_a - ce0), 32'd10);

      // Backpressure
      base = q_a.size(); ce0 = ce_a; v0 = rdy_viol;
      drive_a(FRAME_A, 1, 0, fin);
      check("t2_end", 32'(fin), 32'd1);
      @(negedge clk); #1;
      check_seq_a("t2", base);
      check("t2_ce_cnt", 32'(ce_a - ce0), 32'd10);
      check("t2_rdy_viol", 32'(rdy_viol - v0), 32'd0);

      // Source stall
      base = q_a.size(); ce0 = ce_a; s0 = stall_ce;
      drive_a(FRAME_A, 2, 0, fin);
      check("t3_end", 32'(fin), 32'd1);
      @(negedge clk); #1;
      check_seq_a("t3", base);
      check("t3_stall_ce", 32'(stall_ce - s0), 32'd0);
      check("t3_ce_cnt", 32'(ce_a - ce0), 32'd10);

      // Abort after the 4th symbol, then a clean frame
      base = q_a.size(); d0 = done_a;
      drive_a(FRAME_A, 0, 4, fin);
      check("t4_end", 32'(fin), 32'd1);
      @(negedge clk); @(negedge clk); #1;
      check("t4_no_done", 32'(done_a - d0), 32'd0);
      check("t4_sym_cnt", 32'(q_a.size() - base), 32'd4);
      base = q_a.size();
      drive_a(FRAME_A, 0, 0, fin);
      check("t4b_end", 32'(fin), 32'd1);
      @(negedge clk); #1;
      check_seq_a("t4b", base);

      // Async reset while in TAIL
      drive_a(FRAME_A, 3, 0, fin);
      check("t5_end", 32'(fin), 32'd1);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); #1;
      base = q_a.size();
      drive_a(FRAME_A, 0, 0, fin);
      check("t5b_end", 32'(fin), 32'd1);
      @(negedge clk); #1;
      check_seq_a("t5b", base);

      // Truncated frame, start held high throughout
      base = q_b.size(); d0 = done_b; idx_b = 0; fin = 1'b0;
      b_start = 1'b1; b_out_ready = 1'b1;
      for (int c = 0; c < 100 && !fin; c++) begin
         b_in_valid = (idx_b < 4);
         b_in_bit   = (idx_b < 4) ? FRAME_B[idx_b[1:0]] : 1'b0;
         #1;
         if (b_done) begin
            fin = 1'b1;
            b_start = 1'b0;
         end else begin
            if (b_in_valid && b_in_ready) idx_b++;
            @(negedge clk); #1;
         end
      end
      b_in_valid = 1'b0;
      check("t6_end", 32'(fin), 32'd1);
      @(negedge clk); @(negedge clk); #1;
      check("t6_idle", 32'(b_busy), 32'd0);
      check("t6_done_cnt", 32'(done_b - d0), 32'd1);
      check("t6_len", 32'(q_b.size() - base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         logic [2:0] got;
         got = (base + i < q_b.size()) ? q_b[base + i] : 3'bxxx;
         check($sformatf("t6_z%0d", i), 32'(got[1:0]), 32'(EXP_B[i]));
         check($sformatf("t6_last%0d", i), 32'(got[2]), 32'(i == 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
